// File: rtl/inst_prefetch.sv
// Instruction prefetcher: one outstanding read at a time into a small {inst, pc} FIFO,
// with redirect flush/refetch. Optional counters enabled by defining IPF_PERF_CNT_EN.
module inst_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_s,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef IPF_PERF_CNT_EN
    ,
    output logic [15:0] flush_cnt,
    output logic [15:0] empty_cnt
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]    state_reg, state_next;
    logic [31:0]   fetch_pc_reg, fetch_pc_next;
    logic [31:0]   req_addr_reg;
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [31:0]   inst_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];
    logic          grant, push, pop;

    // A request is only issued when its response is certain to fit in the FIFO.
    assign mem_req  = (state_reg == ST_IDLE) && (count_reg < DEPTH_CNT) && !redirect_valid;
    assign mem_addr = fetch_pc_reg;
    assign grant    = mem_req && mem_gnt;
    assign push     = (state_reg == ST_WAIT) && mem_rvalid && !redirect_valid;
    assign pop      = out_valid && out_ready && !redirect_valid;

    assign out_valid = (count_reg != '0);
    assign out_inst  = out_valid ? inst_mem[rd_ptr_reg] : '0;
    assign out_pc    = out_valid ? pc_mem[rd_ptr_reg]   : '0;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (grant) state_next = ST_WAIT;
            ST_WAIT: begin
                if (mem_rvalid)          state_next = ST_IDLE;
                else if (redirect_valid) state_next = ST_DROP;
            end
            ST_DROP: if (mem_rvalid) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        if (redirect_valid)
            fetch_pc_next = {redirect_pc[31:2], 2'b00};
        else if (grant)
            fetch_pc_next = fetch_pc_reg + 32'd4;
    end

    always_ff @(posedge clk or negedge reset_s) begin
        if (!reset_s) begin
            state_reg    <= ST_IDLE;
            fetch_pc_reg <= RESET_PC;
            req_addr_reg <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            if (grant)
                req_addr_reg <= fetch_pc_reg;
            if (redirect_valid) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
                count_reg <= count_reg + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            end
        end
    end

    // Storage has no reset; the outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr_reg] <= mem_rdata;
            pc_mem[wr_ptr_reg]   <= req_addr_reg;
        end
    end

`ifdef IPF_PERF_CNT_EN
    logic        seen_push_reg;
    logic [15:0] flush_cnt_reg, empty_cnt_reg;

    always_ff @(posedge clk or negedge reset_s) begin
        if (!reset_s) begin
            seen_push_reg <= 1'b0;
            flush_cnt_reg <= '0;
            empty_cnt_reg <= '0;
        end else begin
            if (push)
                seen_push_reg <= 1'b1;
            if (redirect_valid && (flush_cnt_reg != 16'hFFFF))
                flush_cnt_reg <= flush_cnt_reg + 16'd1;
            if (seen_push_reg && !out_valid && (empty_cnt_reg != 16'hFFFF))
                empty_cnt_reg <= empty_cnt_reg + 16'd1;
        end
    end

    assign flush_cnt = flush_cnt_reg;
    assign empty_cnt = empty_cnt_reg;
`endif

endmodule

// File: tb/tb_inst_prefetch.sv
// Directed bench for inst_prefetch: queue-based reference model, per-cycle compare, literal spot checks.
module tb_inst_prefetch;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DATA_OFS = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        reset_s = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
`ifdef IPF_PERF_CNT_EN
    logic [15:0] flush_cnt;
    logic [15:0] empty_cnt;
`endif

    inst_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset_s        (reset_s),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef IPF_PERF_CNT_EN
        ,
        .flush_cnt      (flush_cnt),
        .empty_cnt      (empty_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, act, exp);
        end
    endtask

    // Memory: grants per mem_gnt, answers exactly one cycle after the grant unless held.
    logic        hold = 1'b0;
    logic [31:0] pend[$];
    initial begin
        forever begin
            @(negedge clk);
            if (!hold && pend.size() > 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = pend.pop_front() + DATA_OFS;
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = '0;
            end
            if (reset_s && mem_req && mem_gnt)
                pend.push_back(mem_addr);
        end
    end

    // Reference model: a queue of fetched words plus "read outstanding / to be dropped" flags.
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;
    ent_t        q[$];
    logic [31:0] pop_log[$];
    logic        m_out  = 1'b0;
    logic        m_disc = 1'b0;
    logic [31:0] m_oaddr = '0;
    logic [31:0] m_fpc = RESET_PC;
    logic        m_req;
    logic        exp_req;

    initial begin
        forever begin
            @(posedge clk or negedge reset_s);
            if (!reset_s) begin
                q.delete();
                m_out  = 1'b0;
                m_disc = 1'b0;
                m_fpc  = RESET_PC;
            end else begin
                m_req = !m_out && (q.size() < DEPTH) && !redirect_valid;
                if (redirect_valid) begin
                    q.delete();
                    m_fpc = redirect_pc;
                    if (m_out) begin
                        if (mem_rvalid) begin
                            m_out  = 1'b0;
                            m_disc = 1'b0;
                        end else begin
                            m_disc = 1'b1;
                        end
                    end
                end else begin
                    if (q.size() > 0 && out_ready) begin
                        pop_log.push_back(q[0].pc);
                        void'(q.pop_front());
                    end
                    if (m_out && mem_rvalid) begin
                        if (!m_disc) q.push_back('{mem_rdata, m_oaddr});
                        m_out  = 1'b0;
                        m_disc = 1'b0;
                    end
                    if (m_req && mem_gnt) begin
                        m_out   = 1'b1;
                        m_oaddr = m_fpc;
                        m_fpc   = m_fpc + 32'd4;
                    end
                end
            end
        end
    end

    // Per-cycle compare against the model, mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_s) begin
                exp_req = !m_out && (q.size() < DEPTH) && !redirect_valid;
                check("cyc_mem_req", 32'(mem_req), 32'(exp_req));
                if (exp_req) check("cyc_mem_addr", mem_addr, m_fpc);
                check("cyc_out_valid", 32'(out_valid), 32'(q.size() != 0));
                if (q.size() != 0) begin
                    check("cyc_out_inst", out_inst, q[0].inst);
                    check("cyc_out_pc", out_pc, q[0].pc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(mem_req), 32'd1);
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_inst", out_inst, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0000_0000);

        // Streaming fetch after reset release
        out_ready = 1'b1;
        mem_gnt   = 1'b1;
        reset_s   = 1'b1;
        @(negedge clk);
        check("first_req", 32'(mem_req), 32'd1);
        check("first_addr", mem_addr, 32'h0000_0000);
        @(negedge clk);
        check("valid_1_after_gnt", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("valid_2_after_gnt", 32'(out_valid), 32'd1);
        check("first_pc", out_pc, 32'h0000_0000);
        check("first_inst", out_inst, 32'h1000_0000);
        repeat (10) step();
        check("pop_count", 32'(pop_log.size() >= 4), 32'd1);
        if (pop_log.size() >= 4) begin
            check("pop_pc0", pop_log[0], 32'h0000_0000);
            check("pop_pc1", pop_log[1], 32'h0000_0004);
            check("pop_pc2", pop_log[2], 32'h0000_0008);
            check("pop_pc3", pop_log[3], 32'h0000_000C);
        end

        // Fill with out_ready low: requests stop at DEPTH entries, one pop restarts them
        reset_s = 1'b0;
        step();
        step();
        out_ready = 1'b0;
        reset_s   = 1'b1;
        repeat (12) step();
        @(negedge clk);
        check("full_no_req", 32'(mem_req), 32'd0);
        check("full_valid", 32'(out_valid), 32'd1);
        check("full_head_pc", out_pc, 32'h0000_0000);
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        hold      = 1'b1;
        @(negedge clk);
        check("refill_req", 32'(mem_req), 32'd1);
        check("refill_addr", mem_addr, 32'h0000_0010);
        check("refill_head_pc", out_pc, 32'h0000_0004);

        // Redirect while a read is outstanding: late data must be dropped
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        @(negedge clk);
        check("redir_blocks_req", 32'(mem_req), 32'd0);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("drop_flushed", 32'(out_valid), 32'd0);
        check("drop_no_req", 32'(mem_req), 32'd0);
        step();
        hold = 1'b0;
        @(negedge clk);
        check("drop_wait_rsp", 32'(mem_req), 32'd0);
        @(negedge clk);
        check("drop_done_req", 32'(mem_req), 32'd1);
        check("drop_done_addr", mem_addr, 32'h0000_0100);
        check("drop_done_empty", 32'(out_valid), 32'd0);

        // Redirect in the same cycle as the response
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("same_cyc_req", 32'(mem_req), 32'd1);
        check("same_cyc_addr", mem_addr, 32'h0000_0100);
        check("same_cyc_empty", 32'(out_valid), 32'd0);

        // Fetch address wraps past the top of the address space
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        out_ready      = 1'b1;
        step();
        redirect_valid = 1'b0;
        wait_req("wrap_req_top");
        check("wrap_addr_top", mem_addr, 32'hFFFF_FFFC);
        step();
        wait_req("wrap_req_zero");
        check("wrap_addr_zero", mem_addr, 32'h0000_0000);

        // Reset pulse during an outstanding read, response arrives after release
        step();
        hold    = 1'b1;
        reset_s = 1'b0;
        mem_gnt = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_mem_addr", mem_addr, RESET_PC);
        check("arst_out_inst", out_inst, 32'd0);
        step();
        reset_s = 1'b1;
        hold    = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check("late_rsp_ignored", 32'(out_valid), 32'd0);
        check("late_rsp_req", 32'(mem_req), 32'd1);
        check("late_rsp_addr", mem_addr, RESET_PC);
        step();
        mem_gnt = 1'b1;
        repeat (10) step();
        check("resume_pops", 32'(pop_log.size() > 8), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
